// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic PE: multiplies west/north operands, accumulates K products
// through a carry-lookahead adder, forwards both operands one stage downstream.
module systolic_mac_pe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned K      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_valid_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_valid_in,
  input  logic              clear,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_valid_out,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  output logic              ovf
);

  typedef enum logic {ACC, DONE} state_t;

  state_t              state, state_n;
  logic                fire;
  logic [2*DATA_W-1:0] product;
  logic [ACC_W-1:0]    prod_ext, add_a, sum, acc_n;
  logic                cout, ovf_n;
  logic [31:0]         mac_cnt, cnt_base, cnt_n;

  assign fire     = a_valid_in & b_valid_in;
  assign product  = a_in * b_in;
  assign prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, product};
  // clear restarts from zero, so a fire on the clear cycle becomes the first MAC
  assign add_a    = clear ? '0 : acc_out;
  assign cnt_base = clear ? '0 : mac_cnt;
  assign acc_valid = (state == DONE);

  // Carry-lookahead adder, 4-bit lookahead groups, carry-in tied low
  always_comb begin : cla
    logic [ACC_W-1:0] g, p;
    logic [ACC_W:0]   c;
    logic [3:0]       gg, pp;
    logic             ci;
    g = add_a & prod_ext;
    p = add_a ^ prod_ext;
    c = '0;
    gg = '0;
    pp = '0;
    ci = 1'b0;
    for (int unsigned blk = 0; blk < ACC_W/4; blk++) begin
      gg = g[4*blk +: 4];
      pp = p[4*blk +: 4];
      ci = c[4*blk];
      c[4*blk+1] = gg[0] | (pp[0] & ci);
      c[4*blk+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
      c[4*blk+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                 | (pp[2] & pp[1] & pp[0] & ci);
      c[4*blk+4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                 | (pp[3] & pp[2] & pp[1] & gg[0]) | (&pp & ci);
    end
    sum  = p ^ c[ACC_W-1:0];
    cout = c[ACC_W];
  end

  always_comb begin
    state_n = state;
    acc_n   = acc_out;
    cnt_n   = mac_cnt;
    ovf_n   = ovf;
    if (clear) begin
      state_n = ACC;
      acc_n   = '0;
      cnt_n   = '0;
      ovf_n   = 1'b0;
    end
    if (fire && (clear || state == ACC)) begin
      acc_n = sum;
      cnt_n = cnt_base + 32'd1;
      ovf_n = (ovf & ~clear) | cout;
      if (cnt_base == K - 1) state_n = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACC;
      mac_cnt     <= '0;
      acc_out     <= '0;
      ovf         <= 1'b0;
      a_out       <= '0;
      a_valid_out <= 1'b0;
      b_out       <= '0;
      b_valid_out <= 1'b0;
    end else begin
      state       <= state_n;
      mac_cnt     <= cnt_n;
      acc_out     <= acc_n;
      ovf         <= ovf_n;
      a_out       <= a_in;
      a_valid_out <= a_valid_in;
      b_out       <= b_in;
      b_valid_out <= b_valid_in;
    end
  end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: three PEs (K=4, K=2, K=66100) share stimulus; a scoreboard
// of model predictions is popped after every edge, and each scenario task spot-checks constants.
module tb_systolic_mac_pe;

  logic       clk = 1'b0;
  logic       rst, clear, a_valid_in, b_valid_in;
  logic [7:0] a_in, b_in;

  logic [7:0]  ao  [3];
  logic [7:0]  bo  [3];
  logic        aov [3];
  logic        bov [3];
  logic [31:0] acco[3];
  logic        accv[3];
  logic        ovfo[3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  systolic_mac_pe #(.DATA_W(8), .ACC_W(32), .K(4)) u_k4 (
    .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in),
    .b_valid_in(b_valid_in), .clear(clear), .a_out(ao[0]), .a_valid_out(aov[0]),
    .b_out(bo[0]), .b_valid_out(bov[0]), .acc_out(acco[0]), .acc_valid(accv[0]), .ovf(ovfo[0]));

  systolic_mac_pe #(.DATA_W(8), .ACC_W(32), .K(2)) u_k2 (
    .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in),
    .b_valid_in(b_valid_in), .clear(clear), .a_out(ao[1]), .a_valid_out(aov[1]),
    .b_out(bo[1]), .b_valid_out(bov[1]), .acc_out(acco[1]), .acc_valid(accv[1]), .ovf(ovfo[1]));

  systolic_mac_pe #(.DATA_W(8), .ACC_W(32), .K(66100)) u_kbig (
    .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in),
    .b_valid_in(b_valid_in), .clear(clear), .a_out(ao[2]), .a_valid_out(aov[2]),
    .b_out(bo[2]), .b_valid_out(bov[2]), .acc_out(acco[2]), .acc_valid(accv[2]), .ovf(ovfo[2]));

  typedef struct packed {
    logic [7:0]       a;
    logic             av;
    logic [7:0]       b;
    logic             bv;
    logic [2:0][31:0] acc;
    logic [2:0]       valid;
    logic [2:0]       ovf;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0]     m_acc  [3];
  logic            m_done [3];
  logic            m_ovf  [3];
  longint unsigned m_cnt  [3];
  longint unsigned kv     [3] = '{64'd4, 64'd2, 64'd66100};

  task automatic drive(input logic [7:0] a, input logic av, input logic [7:0] b,
                       input logic bv, input logic clr, input logic r);
    exp_t        e;
    logic [32:0] s;
    a_in = a; a_valid_in = av; b_in = b; b_valid_in = bv; clear = clr; rst = r;
    for (int d = 0; d < 3; d++) begin
      if (r) begin
        m_acc[d] = '0; m_done[d] = 1'b0; m_ovf[d] = 1'b0; m_cnt[d] = 0;
      end else begin
        if (clr) begin
          m_acc[d] = '0; m_done[d] = 1'b0; m_ovf[d] = 1'b0; m_cnt[d] = 0;
        end
        if (av && bv && !m_done[d]) begin
          s = {1'b0, m_acc[d]} + (33'(a) * 33'(b));
          m_acc[d] = s[31:0];
          m_ovf[d] = m_ovf[d] | s[32];
          m_cnt[d] = m_cnt[d] + 1;
          if (m_cnt[d] == kv[d]) m_done[d] = 1'b1;
        end
      end
      e.acc[d]   = m_acc[d];
      e.valid[d] = m_done[d];
      e.ovf[d]   = m_ovf[d];
    end
    e.a  = r ? 8'd0 : a;
    e.av = r ? 1'b0 : av;
    e.b  = r ? 8'd0 : b;
    e.bv = r ? 1'b0 : bv;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // scoreboard consumer: one prediction per clock edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (ao[d] !== e.a || aov[d] !== e.av || bo[d] !== e.b || bov[d] !== e.bv) begin
          n_fail++;
          $display("FAIL sb_fwd pe%0d: got a=%0d av=%b b=%0d bv=%b, want a=%0d av=%b b=%0d bv=%b",
                   d, ao[d], aov[d], bo[d], bov[d], e.a, e.av, e.b, e.bv);
        end
        n_checks++;
        if (acco[d] !== e.acc[d]) begin
          n_fail++;
          $display("FAIL sb_acc pe%0d t=%0t: got %0d, want %0d", d, $time, acco[d], e.acc[d]);
        end
        n_checks++;
        if (accv[d] !== e.valid[d] || ovfo[d] !== e.ovf[d]) begin
          n_fail++;
          $display("FAIL sb_flags pe%0d t=%0t: got valid=%b ovf=%b, want valid=%b ovf=%b",
                   d, $time, accv[d], ovfo[d], e.valid[d], e.ovf[d]);
        end
      end
    end
  end

  task automatic test_reset();
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    drive(8'd7, 1'b1, 8'd7, 1'b1, 1'b1, 1'b1);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (acco[d] !== 32'd0 || accv[d] !== 1'b0 || ovfo[d] !== 1'b0 || ao[d] !== 8'd0 ||
          bo[d] !== 8'd0 || aov[d] !== 1'b0 || bov[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset pe%0d: got acc=%0d v=%b ovf=%b a=%0d b=%0d, want all zero",
                 d, acco[d], accv[d], ovfo[d], ao[d], bo[d]);
      end
    end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 4; i++) begin
      drive(8'd3, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (acco[0] !== 32'(15 * i) || accv[0] !== (i == 4)) begin
        n_fail++;
        $display("FAIL basic step%0d: got acc=%0d v=%b, want acc=%0d v=%b",
                 i, acco[0], accv[0], 15 * i, (i == 4));
      end
      n_checks++;
      if (ao[0] !== 8'd3 || bo[0] !== 8'd5) begin
        n_fail++;
        $display("FAIL basic_fwd step%0d: got a=%0d b=%0d, want 3/5", i, ao[0], bo[0]);
      end
    end
  endtask

  task automatic test_done_hold();
    for (int i = 1; i <= 3; i++) begin
      drive(8'd9, 1'b1, 8'd9, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (acco[0] !== 32'd60 || accv[0] !== 1'b1 || ao[0] !== 8'd9 || bo[0] !== 8'd9) begin
        n_fail++;
        $display("FAIL done_hold step%0d: got acc=%0d v=%b a=%0d b=%0d, want 60/1/9/9",
                 i, acco[0], accv[0], ao[0], bo[0]);
      end
    end
    drive(8'd2, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (acco[0] !== 32'd6 || accv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_fire: got acc=%0d v=%b, want 6/0", acco[0], accv[0]);
    end
    // mac_cnt is 1 after clear-with-fire, so three more fires complete the result
    for (int i = 1; i <= 3; i++) begin
      drive(8'd1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (acco[0] !== 32'(6 + i) || accv[0] !== (i == 3)) begin
        n_fail++;
        $display("FAIL clear_fire_cnt step%0d: got acc=%0d v=%b, want %0d/%b",
                 i, acco[0], accv[0], 6 + i, (i == 3));
      end
    end
  endtask

  task automatic test_interleave();
    logic [7:0] ta [6] = '{8'd2, 8'd5, 8'd8, 8'd10, 8'd1, 8'd4};
    logic [7:0] tb [6] = '{8'd7, 8'd6, 8'd11, 8'd10, 8'd1, 8'd4};
    logic       tav[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       tbv[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(ta[i], tav[i], tb[i], tbv[i], 1'b0, 1'b0);
      n_checks++;
      if (ao[0] !== ta[i] || bo[0] !== tb[i] || aov[0] !== tav[i] || bov[0] !== tbv[i]) begin
        n_fail++;
        $display("FAIL interleave_fwd step%0d: got a=%0d b=%0d, want %0d/%0d",
                 i, ao[0], bo[0], ta[i], tb[i]);
      end
    end
    n_checks++;
    if (acco[0] !== 32'd131 || accv[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL interleave_acc: got acc=%0d v=%b, want 131/1", acco[0], accv[0]);
    end
  endtask

  task automatic test_clear_mid();
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    drive(8'd100, 1'b1, 8'd100, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (acco[1] !== 32'd10000 || accv[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_mid_pre: got acc=%0d v=%b, want 10000/0", acco[1], accv[1]);
    end
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (acco[1] !== 32'd0 || accv[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_mid: got acc=%0d v=%b, want 0/0", acco[1], accv[1]);
    end
    drive(8'd1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
    drive(8'd1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (acco[1] !== 32'd2 || accv[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_mid_post: got acc=%0d v=%b, want 2/1", acco[1], accv[1]);
    end
  endtask

  task automatic test_rst_mid();
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    drive(8'd3, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    drive(8'd3, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (acco[0] !== 32'd30) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got acc=%0d, want 30", acco[0]);
    end
    drive(8'd3, 1'b1, 8'd5, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (acco[0] !== 32'd0 || accv[0] !== 1'b0 || ovfo[0] !== 1'b0 || ao[0] !== 8'd0 ||
        bo[0] !== 8'd0 || aov[0] !== 1'b0 || bov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got acc=%0d v=%b a=%0d b=%0d, want all zero",
               acco[0], accv[0], ao[0], bo[0]);
    end
    for (int i = 1; i <= 4; i++) drive(8'd3, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (acco[0] !== 32'd60 || accv[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_post: got acc=%0d v=%b, want 60/1", acco[0], accv[0]);
    end
  endtask

  task automatic test_overflow();
    longint unsigned wrap;
    logic [31:0]     final_acc;
    wrap = 64'd65025 * 64'd66052 - 64'd4294967296;
    final_acc = '0;
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= 66100; n++) begin
      drive(8'd255, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0);
      if (n == 66051) begin
        n_checks++;
        if (ovfo[2] !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_early: got ovf=%b, want 0", ovfo[2]);
        end
      end
      if (n == 66052) begin
        n_checks++;
        if (ovfo[2] !== 1'b1 || acco[2] !== wrap[31:0]) begin
          n_fail++;
          $display("FAIL ovf_rise: got ovf=%b acc=%0d, want 1/%0d", ovfo[2], acco[2], wrap);
        end
      end
      if (n == 66100) begin
        final_acc = 32'(64'd65025 * 64'd66100);
        n_checks++;
        if (accv[2] !== 1'b1 || ovfo[2] !== 1'b1 || acco[2] !== final_acc) begin
          n_fail++;
          $display("FAIL ovf_done: got v=%b ovf=%b acc=%0d, want 1/1/%0d",
                   accv[2], ovfo[2], acco[2], final_acc);
        end
      end
    end
    drive(8'd255, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (acco[2] !== final_acc || ovfo[2] !== 1'b1 || accv[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_frozen: got acc=%0d ovf=%b v=%b, want %0d/1/1",
               acco[2], ovfo[2], accv[2], final_acc);
    end
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (ovfo[2] !== 1'b0 || acco[2] !== 32'd0 || accv[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got ovf=%b acc=%0d v=%b, want 0/0/0", ovfo[2], acco[2], accv[2]);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; a_in = '0; b_in = '0; a_valid_in = 1'b0; b_valid_in = 1'b0;
    test_reset();
    test_basic();
    test_done_hold();
    test_interleave();
    test_clear_mid();
    test_rst_mid();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
